// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared defaults and small helpers for the BRAM-backed FIFO controller.
package bram_fifo_ctrl_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_DEPTH      = 1024;
    localparam int unsigned DEF_LATENCY    = 1;

    // Increment an index modulo an arbitrary (not necessarily power-of-2) limit.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned lim);
        return ((idx + 1) >= lim) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/bram_fifo_ctrl_obuf.sv
// Small register FIFO holding prefetched RAM words; head entry is the show-ahead output.
module bram_fifo_ctrl_obuf
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned OBUF_DEPTH = 2,
    parameter type         dtype      = logic [31:0],
    localparam int unsigned PW        = $clog2(OBUF_DEPTH),
    localparam int unsigned OW        = $clog2(OBUF_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  dtype          din,
    input  logic          pop,
    output dtype          dout,
    output logic [OW-1:0] count
);

    dtype          mem_q [OBUF_DEPTH];
    dtype          mem_d [OBUF_DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [OW-1:0] count_q, count_d;
    logic          do_pop;

    // Next-state: fill at tail, advance head on pop; both may happen together.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        do_pop  = pop && (count_q != '0);
        if (push) begin
            mem_d[tail_q] = din;
            tail_d        = PW'(wrap_inc(32'(tail_q), OBUF_DEPTH));
        end
        if (do_pop) begin
            head_d = PW'(wrap_inc(32'(head_q), OBUF_DEPTH));
        end
        count_d = count_q + OW'(push) - OW'(do_pop);
    end

    // State registers; entries cleared so dout reads zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(OBUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign dout  = mem_q[head_q];
    assign count = count_q;

    obuf_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count_q == OW'(OBUF_DEPTH))))
        else $error("obuf overflow");

endmodule

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: port A write-only, port B read with LATENCY_B pipeline stages.
module dual_port_ram #(
    parameter int unsigned SIZE      = 1024,
    parameter type         dtype     = logic [31:0],
    parameter int unsigned LATENCY_B = 1,
    localparam int unsigned AW       = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          rsta,
    input  logic          ena,
    input  logic          wea,
    input  logic [AW-1:0] addra,
    input  dtype          dina,
    input  logic          rstb,
    input  logic          enb,
    input  logic          web,
    input  logic [AW-1:0] addrb,
    input  dtype          dinb,
    output dtype          doutb
);

    dtype mem_q  [SIZE];
    dtype pipe_q [LATENCY_B];
    dtype pipe_d [LATENCY_B];

    // Array writes; contents are never cleared by reset.
    always_ff @(posedge clk) begin
        if (ena && wea && !rsta) begin
            mem_q[addra] <= dina;
        end
        if (enb && web && !rstb) begin
            mem_q[addrb] <= dinb;
        end
    end

    // Read pipeline: stage 0 captures the array, later stages just shift.
    always_comb begin
        pipe_d = pipe_q;
        if (enb) begin
            pipe_d[0] = mem_q[addrb];
        end
        for (int i = 1; i < int'(LATENCY_B); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Read pipeline registers, cleared by the port B reset.
    always_ff @(posedge clk) begin
        if (rstb) begin
            for (int i = 0; i < int'(LATENCY_B); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign doutb = pipe_q[LATENCY_B-1];

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Ready/valid FIFO on a dual-port RAM with read prefetch into a show-ahead output buffer.
module bram_fifo_ctrl
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter type         dtype      = logic [DATA_WIDTH-1:0],
    parameter int unsigned LATENCY    = DEF_LATENCY,
    localparam int unsigned OBUF_DEPTH = LATENCY + 1,
    localparam int unsigned AW         = $clog2(DEPTH),
    localparam int unsigned CW         = $clog2(DEPTH + OBUF_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  dtype          in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output dtype          out_data,
    output logic [CW-1:0] occupancy
);

    localparam int unsigned RW = AW + 1;
    localparam int unsigned OW = $clog2(OBUF_DEPTH + 1);
    localparam int unsigned SW = $clog2(2 * OBUF_DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("DEPTH must be a power of 2 and >= 4");
    end
    if (LATENCY < 1) begin : g_lat_chk
        $error("LATENCY must be >= 1");
    end

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [RW-1:0]      ram_cnt_q, ram_cnt_d;
    logic [LATENCY-1:0] inflight_q, inflight_d;
    logic [CW-1:0]      occ_q, occ_d;
    logic               in_ready_q, in_ready_d;
    logic [SW-1:0]      inflight_cnt;
    logic [OW-1:0]      obuf_cnt;
    logic               push_fire, pop_fire, rd_go, obuf_fill;
    dtype               ram_dout;

    assign out_valid = (obuf_cnt != '0);

    // Handshakes, prefetch credit check and next-state for pointers/counters.
    always_comb begin
        push_fire    = in_valid && in_ready_q;
        pop_fire     = out_valid && out_ready;
        inflight_cnt = '0;
        for (int i = 0; i < int'(LATENCY); i++) begin
            inflight_cnt = inflight_cnt + SW'(inflight_q[i]);
        end
        rd_go      = (ram_cnt_q != '0) && ((inflight_cnt + SW'(obuf_cnt)) < SW'(OBUF_DEPTH));
        obuf_fill  = inflight_q[LATENCY-1];
        wr_ptr_d   = push_fire ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = rd_go ? rd_ptr_q + AW'(1) : rd_ptr_q;
        ram_cnt_d  = ram_cnt_q + RW'(push_fire) - RW'(rd_go);
        inflight_d = LATENCY'({inflight_q, rd_go});
        occ_d      = occ_q + CW'(push_fire) - CW'(pop_fire);
        in_ready_d = (ram_cnt_d != RW'(DEPTH));
    end

    // Control state; reset clears the in-flight pipe so late RAM data is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= '0;
            occ_q      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign occupancy = occ_q;

    dual_port_ram #(
        .SIZE      (DEPTH),
        .dtype     (dtype),
        .LATENCY_B (LATENCY)
    ) u_ram (
        .clk   (clk),
        .rsta  (rst),
        .ena   (push_fire),
        .wea   (push_fire),
        .addra (wr_ptr_q),
        .dina  (in_data),
        .rstb  (rst),
        .enb   (rd_go),
        .web   (1'b0),
        .addrb (rd_ptr_q),
        .dinb  ('0),
        .doutb (ram_dout)
    );

    bram_fifo_ctrl_obuf #(
        .OBUF_DEPTH (OBUF_DEPTH),
        .dtype      (dtype)
    ) u_obuf (
        .clk   (clk),
        .rst   (rst),
        .push  (obuf_fill),
        .din   (ram_dout),
        .pop   (pop_fire),
        .dout  (out_data),
        .count (obuf_cnt)
    );

endmodule
